mlp_layer_controller: RTL and testbench
=======================================

// Module: mlp_layer_controller
// PURPOSE
//  Sequences one dense 3x3 NPU layer: y = ReLU(W*x + b) for a 3-element signed vector.
//  Three row accumulators each process one column per cycle, so the layer takes 3 MAC cycles.
//  The block sits between the operand registers/host and the next layer.
//  A start pulse launches one computation; done flags that y0..y2 are valid.
// PARAMETERS
//  DW  16  operand width (x, w); bias, accumulator and outputs are 2*DW wide
// PORTS
//  clk        in   1     rising-edge clock, the block's only clock
//  rst        in   1     reset, asynchronous, active-low
//  start      in   1     launch request, sampled on rising clk
//  x0..x2     in   DW    signed input vector elements
//  w00..w22   in   DW    signed weights; w<r><c> = row r (output), col c (input)
//  b0..b2     in   2*DW  signed per-row bias
//  y0..y2     out  2*DW  signed ReLU outputs, registered
//  done       out  1     result-valid level
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, y0..y2=0, done=0, accumulators and operand latches=0.
//  FSM states: IDLE, MAC0, MAC1, MAC2, RELU, DONE.
//  IDLE/DONE: start=1 at an edge latches all x, w and b into internal regs, clears done, and moves to MAC0.
//    Inputs may change freely after that edge.
//  MAC0: acc_r <= b_r + x0*w_r0 for r=0..2, then go to MAC1.
//  MAC1: acc_r <= acc_r + x1*w_r1, then go to MAC2.
//  MAC2: acc_r <= acc_r + x2*w_r2, then go to RELU.
//  RELU: y_r <= (acc_r > 0) ? acc_r : 0 (signed compare; zero gives 0), done <= 1, then go to DONE.
//  DONE: hold y and done=1 until the next start. Without start the FSM stays in DONE.
//  Latency: start is sampled at edge E0 and done rises at edge E4. The y values are valid in the same cycle done rises.
//  start during MAC0..RELU is ignored. The operation in flight is not disturbed.
//  start held high: each pass through DONE re-launches a computation, and done is high for exactly one cycle per result.
//  y0..y2 change only in RELU. Between results they keep the previous values, including while done=0.
//  Arithmetic:
//    - Products are DW x DW signed to 2*DW signed.
//    - Sums are 2*DW two's-complement and wrap modulo 2^(2*DW), with no saturation.
//    - ReLU is applied to the wrapped value.
//  Reset mid-operation: abort immediately, return to IDLE, and clear the outputs as above. The next start runs normally.
// TESTING
//  T1 x=[3,2,1], W=[4 5 6; -1 2 3; 1 1 1], b=[0,-10,5], start pulse -> y=[28,0,11], done at E4.
//  T2 then x=[4,4,-1], W=[-2 -3 -4; -1 -1 -1; 1 -2 -3], b=[-50,-5,-10] -> y=[0,0,0].
//     done must drop after this start and rise again at E4.
//  T3 dot exactly 0: x=[1,1,0], W row0=[2,-2,7], b0=0 -> y0=0.
//     With b0=1 -> y0=1 (boundary of the ReLU).
//  T4 overflow wrap: all x and w = -32768, b=0 -> acc = 3*2^30, which wraps to 0xC0000000 (negative) -> y=[0,0,0].
//  T5 start re-pulsed at E2 of a run -> that pulse is ignored and the result equals the first launch's values.
//     Change inputs at E1 -> the result is unchanged.
//  T6 rst=0 asynchronously in MAC1 -> y=0 and done=0 immediately.
//     After release, a fresh start gives the T1 values at E4.

Source files
------------

// File: rtl/mlp_layer_controller.sv
// Dense 3x3 layer y = ReLU(W*x + b): start at E0 latches operands, y/done valid at E4.
// No backpressure: start is ignored while a computation is in flight.
module mlp_layer_controller #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   x0,
  input  logic [DW-1:0]   x1,
  input  logic [DW-1:0]   x2,
  input  logic [DW-1:0]   w00,
  input  logic [DW-1:0]   w01,
  input  logic [DW-1:0]   w02,
  input  logic [DW-1:0]   w10,
  input  logic [DW-1:0]   w11,
  input  logic [DW-1:0]   w12,
  input  logic [DW-1:0]   w20,
  input  logic [DW-1:0]   w21,
  input  logic [DW-1:0]   w22,
  input  logic [2*DW-1:0] b0,
  input  logic [2*DW-1:0] b1,
  input  logic [2*DW-1:0] b2,
  output logic [2*DW-1:0] y0,
  output logic [2*DW-1:0] y1,
  output logic [2*DW-1:0] y2,
  output logic            done
);

  localparam int AW = 2 * DW;

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, RELU, DONE} state_t;

  state_t                  state_q, state_d;
  logic [2:0][DW-1:0]      x_in, x_q, x_d;
  logic [2:0][2:0][DW-1:0] w_in, w_q, w_d;   // [row][col]
  logic [2:0][AW-1:0]      b_in, b_q, b_d;
  logic [2:0][AW-1:0]      acc_q, acc_d;
  logic [2:0][AW-1:0]      y_q, y_d;
  logic [2:0][AW-1:0]      prod;
  logic                    done_q, done_d;
  logic [1:0]              col;
  logic [DW-1:0]           x_sel;

  assign x_in = {x2, x1, x0};
  assign w_in = {{w22, w21, w20}, {w12, w11, w10}, {w02, w01, w00}};
  assign b_in = {b2, b1, b0};

  // One input column per MAC state; all three rows share the selected x element.
  always_comb begin
    case (state_q)
      MAC1:    col = 2'd1;
      MAC2:    col = 2'd2;
      default: col = 2'd0;
    endcase
    x_sel = x_q[col];
    for (int r = 0; r < 3; r++) begin
      prod[r] = $signed({{DW{x_sel[DW-1]}}, x_sel})
              * $signed({{DW{w_q[r][col][DW-1]}}, w_q[r][col]});
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    w_d     = w_q;
    b_d     = b_q;
    acc_d   = acc_q;
    y_d     = y_q;
    done_d  = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          x_d     = x_in;
          w_d     = w_in;
          b_d     = b_in;
          done_d  = 1'b0;
          state_d = MAC0;
        end
      end
      MAC0: begin
        for (int r = 0; r < 3; r++) acc_d[r] = b_q[r] + prod[r];
        state_d = MAC1;
      end
      MAC1: begin
        for (int r = 0; r < 3; r++) acc_d[r] = acc_q[r] + prod[r];
        state_d = MAC2;
      end
      MAC2: begin
        for (int r = 0; r < 3; r++) acc_d[r] = acc_q[r] + prod[r];
        state_d = RELU;
      end
      RELU: begin
        // Strictly positive: sign bit clear and not zero; wrapped sums are taken as-is.
        for (int r = 0; r < 3; r++) begin
          y_d[r] = (!acc_q[r][AW-1] && (acc_q[r] != '0)) ? acc_q[r] : '0;
        end
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      w_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      w_q     <= w_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  assign y0   = y_q[0];
  assign y1   = y_q[1];
  assign y2   = y_q[2];
  assign done = done_q;

endmodule

// File: tb/tb_mlp_layer_controller.sv
// Scoreboard bench for mlp_layer_controller: driver queues expected results, monitor checks on done rise.
module tb_mlp_layer_controller;

  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [DW-1:0]   x0, x1, x2;
  logic [DW-1:0]   w00, w01, w02, w10, w11, w12, w20, w21, w22;
  logic [2*DW-1:0] b0, b1, b2;
  logic [2*DW-1:0] y0, y1, y2;
  logic            done;

  typedef struct {
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
    int          at_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t ex;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic done_prev = 1'b0;

  mlp_layer_controller #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .x1(x1), .x2(x2),
    .w00(w00), .w01(w01), .w02(w02),
    .w10(w10), .w11(w11), .w12(w12),
    .w20(w20), .w21(w21), .w22(w22),
    .b0(b0), .b1(b1), .b2(b2),
    .y0(y0), .y1(y1), .y2(y2),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Monitor: every rising edge of done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && done && !done_prev) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done rose at cycle %0d with no result queued", cyc);
      end else begin
        ex = sb.pop_front();
        chk("y0", y0, ex.e0);
        chk("y1", y1, ex.e1);
        chk("y2", y2, ex.e2);
        chk("done_cycle", cyc, ex.at_cyc);
      end
    end
    done_prev <= done;
  end

  task automatic set_all(input int a0, a1, a2,
                         input int m00, m01, m02, m10, m11, m12, m20, m21, m22,
                         input int c0, c1, c2);
    x0 = a0[15:0];  x1 = a1[15:0];  x2 = a2[15:0];
    w00 = m00[15:0]; w01 = m01[15:0]; w02 = m02[15:0];
    w10 = m10[15:0]; w11 = m11[15:0]; w12 = m12[15:0];
    w20 = m20[15:0]; w21 = m21[15:0]; w22 = m22[15:0];
    b0 = c0; b1 = c1; b2 = c2;
  endtask

  task automatic set_t1();
    set_all(3, 2, 1,  4, 5, 6,  -1, 2, 3,  1, 1, 1,  0, -10, 5);
  endtask

  task automatic set_t2();
    set_all(4, 4, -1,  -2, -3, -4,  -1, -1, -1,  1, -2, -3,  -50, -5, -10);
  endtask

  // Drives a one-cycle start pulse; returns at the negedge after E0.
  task automatic launch(input bit push, input int e0, e1, e2);
    exp_t item;
    @(negedge clk);
    start = 1'b1;
    if (push) begin
      item.e0 = e0; item.e1 = e1; item.e2 = e2; item.at_cyc = cyc + 5;
      sb.push_back(item);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t item;
    int   c;
    set_t1();
    #12;
    chk("reset_y0", y0, 0);
    chk("reset_y1", y1, 0);
    chk("reset_y2", y2, 0);
    chk("reset_done", {31'd0, done}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // T1
    set_t1();
    launch(1'b1, 28, 0, 11);
    wait_drain();

    // T2: done must drop right after the new start
    set_t2();
    launch(1'b1, 0, 0, 0);
    chk("t2_done_drop", {31'd0, done}, 0);
    wait_drain();

    // T3: ReLU boundary at exactly zero, then one
    set_all(1, 1, 0,  2, -2, 7,  1, 1, 1,  0, 0, 0,  0, 0, -1);
    launch(1'b1, 0, 2, 0);
    wait_drain();
    set_all(1, 1, 0,  2, -2, 7,  1, 1, 1,  0, 0, 0,  1, 0, -1);
    launch(1'b1, 1, 2, 0);
    wait_drain();

    // T4: wrap to 0xC0000000, negative
    set_all(-32768, -32768, -32768,
            -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768,
            0, 0, 0);
    launch(1'b1, 0, 0, 0);
    wait_drain();

    // T5: inputs change after E0, start re-pulsed at E2; both ignored
    @(negedge clk);
    set_t1();
    start = 1'b1;
    item.e0 = 28; item.e1 = 0; item.e2 = 11; item.at_cyc = cyc + 5;
    sb.push_back(item);
    @(negedge clk);
    start = 1'b0;
    set_t2();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (10) @(negedge clk);

    // T6: async reset while in MAC1
    set_t1();
    launch(1'b0, 0, 0, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_y0", y0, 0);
    chk("t6_rst_y1", y1, 0);
    chk("t6_rst_y2", y2, 0);
    chk("t6_rst_done", {31'd0, done}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    launch(1'b1, 28, 0, 11);
    wait_drain();

    // start held high: back-to-back results, done pulses once per result
    set_t2();
    @(negedge clk);
    start = 1'b1;
    c = cyc;
    item.e0 = 0; item.e1 = 0; item.e2 = 0; item.at_cyc = c + 5;
    sb.push_back(item);
    item.at_cyc = c + 10;
    sb.push_back(item);
    repeat (10) @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (8) @(negedge clk);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
